// File: rtl/intersection_pkg.sv
// Shared types and constants for the 4-way intersection controller.
//   phase_t      : 8 normal phases plus the 4 emergency phases
//   LAMP_*       : one-hot {R,Y,G} lamp encodings
//   LED_CODE_*   : legacy 3-bit phase codes
//   lamp_t       : bundle of every lamp/LED output
//   decode_phase : maps a phase (and emergency road selects) to lamp_t
package intersection_pkg;

    typedef enum logic [3:0] {
        N_GREEN   = 4'd0,
        N_YELLOW  = 4'd1,
        RED_1     = 4'd2,
        E_LEFT    = 4'd3,
        E_GREEN   = 4'd4,
        E_YELLOW  = 4'd5,
        RED_2     = 4'd6,
        N_LEFT    = 4'd7,
        EM_CLEAR  = 4'd8,
        EM_ALLRED = 4'd9,
        EM_GREEN  = 4'd10,
        EM_YELLOW = 4'd11
    } phase_t;

    localparam logic [2:0] LAMP_R = 3'b100;
    localparam logic [2:0] LAMP_Y = 3'b010;
    localparam logic [2:0] LAMP_G = 3'b001;

    localparam logic [2:0] LED_CODE_N_GREEN  = 3'd0;
    localparam logic [2:0] LED_CODE_N_YELLOW = 3'd1;
    localparam logic [2:0] LED_CODE_RED_1    = 3'd2;
    localparam logic [2:0] LED_CODE_E_LEFT   = 3'd3;
    localparam logic [2:0] LED_CODE_E_GREEN  = 3'd4;
    localparam logic [2:0] LED_CODE_E_YELLOW = 3'd5;
    localparam logic [2:0] LED_CODE_RED_2    = 3'd6;
    localparam logic [2:0] LED_CODE_N_LEFT   = 3'd7;

    // Pedestrian walk window length, ticks.
    localparam int T_WALK = 5;

    typedef struct packed {
        logic [2:0] n_light;
        logic [2:0] e_light;
        logic       n_left;
        logic       e_left;
        logic [2:0] led_code;
        logic       emerg_active;
    } lamp_t;

    function automatic logic is_em(phase_t ph);
        return (ph == EM_CLEAR) || (ph == EM_ALLRED) || (ph == EM_GREEN) || (ph == EM_YELLOW);
    endfunction

    // dir_e: emergency target road is E.  clr_e: EM_CLEAR is clearing the E road.
    function automatic lamp_t decode_phase(phase_t ph, logic dir_e, logic clr_e);
        lamp_t d;
        d.n_light      = LAMP_R;
        d.e_light      = LAMP_R;
        d.n_left       = 1'b0;
        d.e_left       = 1'b0;
        d.led_code     = LED_CODE_N_GREEN;
        d.emerg_active = 1'b0;
        case (ph)
            N_GREEN:  d.n_light = LAMP_G;
            N_YELLOW: begin
                d.n_light  = LAMP_Y;
                d.led_code = LED_CODE_N_YELLOW;
            end
            RED_1:    d.led_code = LED_CODE_RED_1;
            E_LEFT: begin
                d.e_left   = 1'b1;
                d.led_code = LED_CODE_E_LEFT;
            end
            E_GREEN: begin
                d.e_light  = LAMP_G;
                d.led_code = LED_CODE_E_GREEN;
            end
            E_YELLOW: begin
                d.e_light  = LAMP_Y;
                d.led_code = LED_CODE_E_YELLOW;
            end
            RED_2:    d.led_code = LED_CODE_RED_2;
            N_LEFT: begin
                d.n_left   = 1'b1;
                d.led_code = LED_CODE_N_LEFT;
            end
            EM_CLEAR, EM_YELLOW: begin
                d.emerg_active = 1'b1;
                // EM_CLEAR yellows the road being cleared, EM_YELLOW the target road.
                if ((ph == EM_CLEAR) ? clr_e : dir_e) begin
                    d.e_light  = LAMP_Y;
                    d.led_code = LED_CODE_E_YELLOW;
                end else begin
                    d.n_light  = LAMP_Y;
                    d.led_code = LED_CODE_N_YELLOW;
                end
            end
            EM_ALLRED: begin
                d.emerg_active = 1'b1;
                d.led_code     = LED_CODE_RED_1;
            end
            EM_GREEN: begin
                d.emerg_active = 1'b1;
                if (dir_e) begin
                    d.e_light  = LAMP_G;
                    d.led_code = LED_CODE_E_GREEN;
                end else begin
                    d.n_light  = LAMP_G;
                    d.led_code = LED_CODE_N_GREEN;
                end
            end
            default:  d.n_light = LAMP_G;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/intersection_ctrl_if.sv
// Board-side signal bundle of the intersection controller.
//   master : controller view (sensor/switch inputs in, lamps/LEDs out)
//   slave  : board view (drives sensors/switches, receives lamps/LEDs)
// PED_WALK_EN adds ped_req / walk_n / walk_e.
interface intersection_ctrl_if;
    logic       sensor_e;
    logic       emerg_req;
    logic       emerg_dir;
    logic [2:0] n_light;
    logic [2:0] e_light;
    logic       n_left;
    logic       e_left;
    logic [2:0] led_code;
    logic       emerg_active;
`ifdef PED_WALK_EN
    logic       ped_req;
    logic       walk_n;
    logic       walk_e;
`endif

`ifdef PED_WALK_EN
    modport master (
        input  sensor_e, emerg_req, emerg_dir, ped_req,
        output n_light, e_light, n_left, e_left, led_code, emerg_active, walk_n, walk_e
    );
    modport slave (
        output sensor_e, emerg_req, emerg_dir, ped_req,
        input  n_light, e_light, n_left, e_left, led_code, emerg_active, walk_n, walk_e
    );
`else
    modport master (
        input  sensor_e, emerg_req, emerg_dir,
        output n_light, e_light, n_left, e_left, led_code, emerg_active
    );
    modport slave (
        output sensor_e, emerg_req, emerg_dir,
        input  n_light, e_light, n_left, e_left, led_code, emerg_active
    );
`endif
endinterface

// File: rtl/tick_prescaler.sv
// Timing-tick prescaler: tick is high for one cycle every TICK_DIV cycles.
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   restart : count restarts from zero on the next edge (phase change)
//   tick    : one-cycle pulse on the last cycle of each TICK_DIV window
module tick_prescaler #(
    parameter int TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic resetn,
    input  logic restart,
    output logic tick
);
    localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [W-1:0] TC = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == TC);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (restart || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end
endmodule

// File: rtl/intersection_ctrl.sv
// 4-way traffic-light controller with latched E sensor, emergency pre-emption
// and legacy 3-bit led_code.
//   clk     : system clock
//   resetn  : synchronous active-low reset
//   bus     : intersection_ctrl_if.master (sensors in, lamps/LEDs out)
// Optional feature macro: PED_WALK_EN (pedestrian walk request and lamps).
//
// state     | meaning
// N_GREEN   | N green, waits for E request and minimum green
// N_YELLOW  | N yellow
// RED_1     | all-red before E phases
// E_LEFT    | E protected left arrow
// E_GREEN   | E green
// E_YELLOW  | E yellow
// RED_2     | all-red before N phases
// N_LEFT    | N protected left arrow
// EM_CLEAR  | emergency: yellow on the road being cleared
// EM_ALLRED | emergency: all-red clearance
// EM_GREEN  | emergency: target road green, held while requested
// EM_YELLOW | emergency: target road yellow before resuming
module intersection_ctrl
    import intersection_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int CNT_W       = 8,
    parameter int T_GREEN_MIN = 10,
    parameter int T_GREEN_E   = 10,
    parameter int T_YELLOW    = 5,
    parameter int T_ALLRED    = 2,
    parameter int T_LEFT      = 10,
    parameter int T_EM_HOLD   = 5
) (
    input logic             clk,
    input logic             resetn,
    intersection_ctrl_if.master bus
);
    localparam logic [CNT_W-1:0] GMIN      = CNT_W'(T_GREEN_MIN);
    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(T_GREEN_MIN - 1);

    phase_t           state, state_nx;
    logic [CNT_W-1:0] phase_cnt;
    logic             req_e;
    logic             em_dir, dir_nx;
    logic             clr_e, clr_nx;
    logic             em_pend, pend_nx;
    logic             hold_rst;
    logic             restart;
    logic             tick;
    logic             expired;
    logic             gmin_done;
    logic             accept;
    logic             walk_busy;
    lamp_t            out_q;

    function automatic logic [CNT_W-1:0] last_tick(phase_t ph);
        case (ph)
            N_GREEN:                                 return GMIN_LAST;
            N_YELLOW, E_YELLOW, EM_CLEAR, EM_YELLOW: return CNT_W'(T_YELLOW - 1);
            RED_1, RED_2, EM_ALLRED:                 return CNT_W'(T_ALLRED - 1);
            E_LEFT, N_LEFT:                          return CNT_W'(T_LEFT - 1);
            E_GREEN:                                 return CNT_W'(T_GREEN_E - 1);
            EM_GREEN:                                return CNT_W'(T_EM_HOLD - 1);
            default:                                 return '0;
        endcase
    endfunction

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_prescaler (
        .clk     (clk),
        .resetn  (resetn),
        .restart (restart),
        .tick    (tick)
    );

    assign expired   = tick && (phase_cnt == last_tick(state));
    // N_GREEN counter saturates at GMIN, so either already saturated or saturating now.
    assign gmin_done = (phase_cnt == GMIN) || (tick && (phase_cnt == GMIN_LAST));
    // A pending emergency (caught in a yellow) blocks re-capture of emerg_dir.
    assign accept    = bus.emerg_req && !is_em(state) && !em_pend;
    assign restart   = (state_nx != state) || hold_rst;

    always_comb begin
        state_nx = state;
        dir_nx   = em_dir;
        clr_nx   = clr_e;
        pend_nx  = em_pend;
        hold_rst = 1'b0;
        if (accept) begin
            dir_nx = bus.emerg_dir;
        end
        case (state)
            N_GREEN: begin
                if (accept) begin
                    if (!bus.emerg_dir) begin
                        state_nx = EM_GREEN;
                    end else begin
                        state_nx = EM_CLEAR;
                        clr_nx   = 1'b0;
                    end
                end else if (req_e && gmin_done && !walk_busy) begin
                    state_nx = N_YELLOW;
                end
            end
            N_YELLOW, E_YELLOW: begin
                if (accept) begin
                    pend_nx = 1'b1;
                end
                if (expired) begin
                    if (em_pend || accept) begin
                        state_nx = EM_ALLRED;
                        pend_nx  = 1'b0;
                    end else begin
                        state_nx = (state == N_YELLOW) ? RED_1 : RED_2;
                    end
                end
            end
            RED_1, RED_2: begin
                if (accept) begin
                    state_nx = EM_ALLRED;
                end else if (expired) begin
                    state_nx = (state == RED_1) ? E_LEFT : N_LEFT;
                end
            end
            E_LEFT: begin
                if (accept) begin
                    state_nx = EM_CLEAR;
                    clr_nx   = 1'b1;
                end else if (expired) begin
                    state_nx = E_GREEN;
                end
            end
            E_GREEN: begin
                if (accept) begin
                    if (bus.emerg_dir) begin
                        state_nx = EM_GREEN;
                    end else begin
                        state_nx = EM_CLEAR;
                        clr_nx   = 1'b1;
                    end
                end else if (expired) begin
                    state_nx = E_YELLOW;
                end
            end
            N_LEFT: begin
                if (accept) begin
                    state_nx = EM_CLEAR;
                    clr_nx   = 1'b0;
                end else if (expired) begin
                    state_nx = N_GREEN;
                end
            end
            EM_CLEAR: begin
                if (expired) state_nx = EM_ALLRED;
            end
            EM_ALLRED: begin
                if (expired) state_nx = EM_GREEN;
            end
            EM_GREEN: begin
                // Hold timer stays at zero while the request is present.
                if (bus.emerg_req) begin
                    hold_rst = 1'b1;
                end else if (expired) begin
                    state_nx = EM_YELLOW;
                end
            end
            EM_YELLOW: begin
                if (expired) state_nx = em_dir ? RED_2 : RED_1;
            end
            default: state_nx = N_GREEN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= N_GREEN;
            phase_cnt <= '0;
            req_e     <= 1'b0;
            em_dir    <= 1'b0;
            clr_e     <= 1'b0;
            em_pend   <= 1'b0;
            out_q     <= decode_phase(N_GREEN, 1'b0, 1'b0);
        end else begin
            state   <= state_nx;
            em_dir  <= dir_nx;
            clr_e   <= clr_nx;
            em_pend <= pend_nx;
            out_q   <= decode_phase(state_nx, dir_nx, clr_nx);
            if (restart) begin
                phase_cnt <= '0;
            end else if (tick && !(state == N_GREEN && phase_cnt == GMIN)) begin
                phase_cnt <= phase_cnt + CNT_W'(1);
            end
            if (state_nx == N_YELLOW && state != N_YELLOW) begin
                req_e <= bus.sensor_e;
            end else begin
                req_e <= req_e | bus.sensor_e;
            end
        end
    end

    assign bus.n_light      = out_q.n_light;
    assign bus.e_light      = out_q.e_light;
    assign bus.n_left       = out_q.n_left;
    assign bus.e_left       = out_q.e_left;
    assign bus.led_code     = out_q.led_code;
    assign bus.emerg_active = out_q.emerg_active;

`ifdef PED_WALK_EN
    localparam logic [2:0] WALK_LAST = 3'(T_WALK - 1);

    logic       ped_q;
    logic       walk_on, walk_on_nx;
    logic [2:0] walk_cnt;
    logic       green_entry;
    logic       walk_n_q, walk_e_q;

    assign green_entry = (state_nx != state) && (state_nx == N_GREEN || state_nx == E_GREEN);
    // Still walking after this edge; lets N_GREEN leave on the same edge the walk ends.
    assign walk_busy   = walk_on && !(tick && walk_cnt == WALK_LAST);

    always_comb begin
        walk_on_nx = walk_on;
        if (green_entry) begin
            walk_on_nx = ped_q || bus.ped_req;
        end else if (state_nx != state) begin
            walk_on_nx = 1'b0;
        end else if (!walk_busy) begin
            walk_on_nx = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ped_q    <= 1'b0;
            walk_on  <= 1'b0;
            walk_cnt <= '0;
            walk_n_q <= 1'b0;
            walk_e_q <= 1'b0;
        end else begin
            ped_q    <= green_entry ? 1'b0 : (ped_q | bus.ped_req);
            walk_on  <= walk_on_nx;
            walk_n_q <= walk_on_nx && (state_nx == N_GREEN);
            walk_e_q <= walk_on_nx && (state_nx == E_GREEN);
            if (green_entry) begin
                walk_cnt <= '0;
            end else if (walk_on && tick) begin
                walk_cnt <= walk_cnt + 3'd1;
            end
        end
    end

    assign bus.walk_n = walk_n_q;
    assign bus.walk_e = walk_e_q;
`else
    assign walk_busy = 1'b0;
`endif

endmodule

// File: tb/tb_intersection_ctrl.sv
module tb_intersection_ctrl;
    logic clk;
    logic resetn;
    int   checks;
    int   errors;
    int   cyc;

    intersection_ctrl_if bus();

    intersection_ctrl #(
        .TICK_DIV    (4),
        .CNT_W       (8),
        .T_GREEN_MIN (3),
        .T_GREEN_E   (2),
        .T_YELLOW    (2),
        .T_ALLRED    (1),
        .T_LEFT      (2),
        .T_EM_HOLD   (2)
    ) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int n);
        while (cyc < n) step();
    endtask

    task automatic do_reset();
        resetn        = 1'b0;
        bus.sensor_e  = 1'b0;
        bus.emerg_req = 1'b0;
        bus.emerg_dir = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        resetn = 1'b1;
        cyc    = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (bus.n_light !== 3'b001) begin errors++; $display("FAIL rst_n_light got=%b exp=001", bus.n_light); end
        checks++; if (bus.e_light !== 3'b100) begin errors++; $display("FAIL rst_e_light got=%b exp=100", bus.e_light); end
        checks++; if ({bus.n_left, bus.e_left} !== 2'b00) begin errors++; $display("FAIL rst_lefts got=%b exp=00", {bus.n_left, bus.e_left}); end
        checks++; if (bus.led_code !== 3'd0) begin errors++; $display("FAIL rst_led got=%0d exp=0", bus.led_code); end
        checks++; if (bus.emerg_active !== 1'b0) begin errors++; $display("FAIL rst_emerg got=%b exp=0", bus.emerg_active); end
        for (int i = 1; i <= 5; i++) begin
            run_to(i * 20);
            checks++;
            if (bus.led_code !== 3'd0 || bus.n_light !== 3'b001 || bus.e_light !== 3'b100) begin
                errors++;
                $display("FAIL idle_hold cyc=%0d got led=%0d n=%b e=%b exp led=0 n=001 e=100", cyc, bus.led_code, bus.n_light, bus.e_light);
            end
        end
    endtask

    task automatic test_full_cycle();
        logic [2:0] codes [7];
        int         lens  [7];
        codes = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7};
        lens  = '{8, 4, 8, 8, 8, 4, 8};
        do_reset();
        run_to(2);
        bus.sensor_e = 1'b1;
        step();
        bus.sensor_e = 1'b0;
        run_to(11);
        checks++; if (bus.led_code !== 3'd0) begin errors++; $display("FAIL ng_last cyc=%0d got=%0d exp=0", cyc, bus.led_code); end
        step();
        checks++; if (bus.n_light !== 3'b010) begin errors++; $display("FAIL ny_lamp got=%b exp=010", bus.n_light); end
        for (int p = 0; p < 7; p++) begin
            for (int i = 0; i < lens[p]; i++) begin
                checks++;
                if (bus.led_code !== codes[p]) begin
                    errors++;
                    $display("FAIL phase_led cyc=%0d got=%0d exp=%0d", cyc, bus.led_code, codes[p]);
                end
                if (p == 2 && i == 0) begin
                    checks++;
                    if (bus.e_left !== 1'b1 || bus.e_light !== 3'b100 || bus.n_light !== 3'b100) begin
                        errors++;
                        $display("FAIL e_left_lamps got left=%b e=%b n=%b exp left=1 e=100 n=100", bus.e_left, bus.e_light, bus.n_light);
                    end
                end
                step();
            end
        end
        checks++; if (bus.led_code !== 3'd0) begin errors++; $display("FAIL wrap_ng cyc=%0d got=%0d exp=0", cyc, bus.led_code); end
        run_to(80);
        checks++; if (bus.led_code !== 3'd0) begin errors++; $display("FAIL req_cleared cyc=%0d got=%0d exp=0", cyc, bus.led_code); end
    endtask

    task automatic test_em_clear();
        do_reset();
        run_to(5);
        bus.emerg_req = 1'b1;
        bus.emerg_dir = 1'b1;
        step();
        checks++;
        if (bus.emerg_active !== 1'b1 || bus.n_light !== 3'b010 || bus.e_light !== 3'b100) begin
            errors++;
            $display("FAIL emclr_lamps got em=%b n=%b e=%b exp em=1 n=010 e=100", bus.emerg_active, bus.n_light, bus.e_light);
        end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (bus.led_code !== ((i < 8) ? 3'd1 : 3'd2)) begin
                errors++;
                $display("FAIL emclr_led cyc=%0d got=%0d exp=%0d", cyc, bus.led_code, (i < 8) ? 1 : 2);
            end
            step();
        end
        checks++;
        if (bus.e_light !== 3'b001 || bus.n_light !== 3'b100 || bus.led_code !== 3'd4 || bus.emerg_active !== 1'b1) begin
            errors++;
            $display("FAIL emgrn_e cyc=%0d got e=%b n=%b led=%0d em=%b exp e=001 n=100 led=4 em=1", cyc, bus.e_light, bus.n_light, bus.led_code, bus.emerg_active);
        end
        run_to(20);
        bus.emerg_dir = 1'b0;
        run_to(30);
        bus.emerg_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.led_code !== ((i < 8) ? 3'd4 : 3'd5)) begin
                errors++;
                $display("FAIL emhold_led cyc=%0d got=%0d exp=%0d", cyc, bus.led_code, (i < 8) ? 4 : 5);
            end
            if (i == 8) begin
                checks++;
                if (bus.e_light !== 3'b010) begin errors++; $display("FAIL emyel_lamp got=%b exp=010", bus.e_light); end
            end
            step();
        end
        checks++;
        if (bus.led_code !== 3'd6 || bus.emerg_active !== 1'b0) begin
            errors++;
            $display("FAIL em_resume cyc=%0d got led=%0d em=%b exp led=6 em=0", cyc, bus.led_code, bus.emerg_active);
        end
        run_to(50);
        checks++;
        if (bus.led_code !== 3'd7 || bus.n_left !== 1'b1) begin
            errors++;
            $display("FAIL em_nleft cyc=%0d got led=%0d left=%b exp led=7 left=1", cyc, bus.led_code, bus.n_left);
        end
    endtask

    task automatic test_em_target_hold();
        do_reset();
        bus.emerg_req = 1'b1;
        bus.emerg_dir = 1'b0;
        step();
        checks++;
        if (bus.led_code !== 3'd0 || bus.emerg_active !== 1'b1 || bus.n_light !== 3'b001) begin
            errors++;
            $display("FAIL emdirect got led=%0d em=%b n=%b exp led=0 em=1 n=001", bus.led_code, bus.emerg_active, bus.n_light);
        end
        run_to(4);
        bus.emerg_req = 1'b0;
        run_to(6);
        bus.emerg_req = 1'b1;
        step();
        bus.emerg_req = 1'b0;
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (bus.led_code !== ((i < 8) ? 3'd0 : 3'd1) || bus.emerg_active !== 1'b1) begin
                errors++;
                $display("FAIL rehold cyc=%0d got led=%0d em=%b exp led=%0d em=1", cyc, bus.led_code, bus.emerg_active, (i < 8) ? 0 : 1);
            end
            step();
        end
        checks++;
        if (bus.led_code !== 3'd2 || bus.emerg_active !== 1'b0) begin
            errors++;
            $display("FAIL rehold_red1 cyc=%0d got led=%0d em=%b exp led=2 em=0", cyc, bus.led_code, bus.emerg_active);
        end
        run_to(27);
        checks++; if (bus.led_code !== 3'd3) begin errors++; $display("FAIL rehold_eleft cyc=%0d got=%0d exp=3", cyc, bus.led_code); end
    endtask

    task automatic test_em_in_yellow();
        do_reset();
        bus.sensor_e = 1'b1;
        step();
        bus.sensor_e = 1'b0;
        run_to(14);
        bus.emerg_req = 1'b1;
        bus.emerg_dir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (bus.led_code !== ((i < 6) ? 3'd1 : 3'd2) || bus.emerg_active !== (i >= 6)) begin
                errors++;
                $display("FAIL yel_em cyc=%0d got led=%0d em=%b exp led=%0d em=%0d", cyc, bus.led_code, bus.emerg_active, (i < 6) ? 1 : 2, (i >= 6) ? 1 : 0);
            end
            step();
        end
        checks++;
        if (bus.led_code !== 3'd4 || bus.e_light !== 3'b001) begin
            errors++;
            $display("FAIL yel_emgrn cyc=%0d got led=%0d e=%b exp led=4 e=001", cyc, bus.led_code, bus.e_light);
        end
        bus.emerg_req = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.sensor_e = 1'b1;
        step();
        bus.sensor_e = 1'b0;
        run_to(34);
        checks++; if (bus.led_code !== 3'd4) begin errors++; $display("FAIL pre_rst_eg cyc=%0d got=%0d exp=4", cyc, bus.led_code); end
        resetn       = 1'b0;
        bus.sensor_e = 1'b1;
        step();
        checks++;
        if (bus.n_light !== 3'b001 || bus.e_light !== 3'b100 || bus.led_code !== 3'd0 ||
            bus.n_left !== 1'b0 || bus.e_left !== 1'b0 || bus.emerg_active !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst got n=%b e=%b led=%0d lefts=%b%b em=%b exp n=001 e=100 led=0 lefts=00 em=0",
                     bus.n_light, bus.e_light, bus.led_code, bus.n_left, bus.e_left, bus.emerg_active);
        end
        resetn = 1'b1;
        run_to(46);
        checks++; if (bus.led_code !== 3'd0) begin errors++; $display("FAIL relatch_ng cyc=%0d got=%0d exp=0", cyc, bus.led_code); end
        step();
        checks++; if (bus.led_code !== 3'd1) begin errors++; $display("FAIL relatch_ny cyc=%0d got=%0d exp=1", cyc, bus.led_code); end
        bus.sensor_e = 1'b0;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        cyc           = 0;
        resetn        = 1'b0;
        bus.sensor_e  = 1'b0;
        bus.emerg_req = 1'b0;
        bus.emerg_dir = 1'b0;
`ifdef PED_WALK_EN
        bus.ped_req   = 1'b0;
`endif
        test_reset();
        test_full_cycle();
        test_em_clear();
        test_em_target_hold();
        test_em_in_yellow();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
